demux1_4_buf: RTL and testbench
===============================

Name: demux1_4_buf

Overview:
- Registered 1-to-4 demultiplexer: the distribution-side counterpart of the 4:1 select mux.
- Accepts one W-bit word per handshake on a single input stream.
- Steers each word into one of four output lanes, each holding a one-entry buffer with valid/ready.
- Lane choice comes from an explicit select or from an internal round-robin pointer (auto mode). Sits between a single producer and four independent consumers.

Parameters:
- W, 2, data width of input and of each output lane.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i  input  W  input data word
- i_valid  input  1  producer has a word on i
- i_ready  output  1  block accepts the word this cycle
- s  input  2  lane select (manual mode); 0..3 maps to o0..o3
- auto_en  input  1  1 = round-robin lane selection, 0 = use s
- o0, o1, o2, o3  output  W  lane data (registered)
- o_valid  output  4  bit k = lane k buffer full
- o_ready  input  4  bit k = consumer k takes o_k this cycle
- cur_sel  output  2  target lane this cycle (s or round-robin pointer)
- acc_cnt  output  CNT_W  number of words accepted, wrapping

Behaviour:
- Reset (rst_n low, async):
  - o0..o3 = 0; o_valid = 4'b0000; round-robin pointer rr = 0; acc_cnt = 0.
  - All buffered words are discarded, including mid-transfer.
  - Outputs hold reset values until the first clk edge after rst_n rises.
- Target lane t = auto_en ? rr : s; cur_sel = t (combinational).
- Ready and accept:
  - i_ready = !o_valid[t] | o_ready[t] (combinational; no dependence on i_valid).
  - Accept = i_valid & i_ready, sampled at the rising edge.
- On accept:
  - lane t data <= i; o_valid[t] <= 1; acc_cnt <= acc_cnt + 1 (wraps 2^CNT_W-1 -> 0).
  - If auto_en = 1: rr <= rr + 1 mod 4 (3 wraps to 0).
- Lane drain: for each k, if o_valid[k] & o_ready[k] and lane k is not written this cycle, then o_valid[k] <= 0.
  - o_k keeps its last value after drain (no clearing).
- Simultaneous drain and write on the same lane: the new word replaces the old; o_valid stays 1. No bubble, no loss.
- Writes and drains on different lanes in the same cycle are independent.
- Latency: a word accepted at edge n appears on o_t with o_valid[t] = 1 immediately after edge n (1 cycle from i_valid/i_ready high).
- Full lane, no o_ready: i_ready = 0 and the word stays with the producer. The producer must hold i stable while i_valid = 1 and i_ready = 0.
- Non-target lanes never block input; a full lane 2 does not stall traffic aimed at lane 0.
- auto_en transitions:
  - rr holds its value while auto_en = 0.
  - Switching auto_en takes effect on the current cycle's t.
  - rr is not reset by the switch.
- s changing while i_valid = 1 and i_ready = 0 retargets the pending word; this is legal.
- No accept when i_valid = 0, regardless of i_ready.
- Only state: 4 × W data, 4 valid flags, 2-bit rr, CNT_W counter.

Test Plan:
- Reset: hold rst_n = 0 with i_valid = 1 and i = 2'b11 → o0..o3 = 0, o_valid = 0000, acc_cnt = 0, i_ready = 1. Assert rst_n low mid-burst → o_valid = 0000 asynchronously, before the next clk edge.
- Manual steering, o_ready = 4'b1111, auto_en = 0, one word per cycle:
  - (i=01,s=00), (10,00), (01,01), (10,01), (01,10), (10,10), (01,11), (10,11).
  - Each word appears on the selected o_k one cycle later with the matching o_valid bit; unselected lanes unchanged.
  - acc_cnt = 8.
- Backpressure, o_ready = 0000, s = 2'b10:
  - Send 01 → o2 = 01, o_valid = 0100, i_ready = 0.
  - Second word 10 is held.
  - Raise o_ready[2] → 10 is written the same edge o2 drains; o2 = 10, o_valid[2] stays 1, acc_cnt = 2.
- Non-blocking lanes: lane 2 full with o_ready[2] = 0; set s = 00, i = 11 → i_ready = 1, o0 = 11 next cycle, lane 2 unchanged.
- Round-robin, auto_en = 1, o_ready = 1111: send 00,01,10,11,01 → land on o0,o1,o2,o3,o0; cur_sel sequence 0,1,2,3,0 (wrap verified). Drop auto_en → rr holds at 1, s steers.
- Counter wrap: accept 256 words → acc_cnt returns to 0; the 257th accept → 1.

Source files
------------

// File: rtl/demux1_4_buf.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready buffer per lane.
// The target lane comes from s, or from a round-robin pointer when auto_en is set.
module demux1_4_buf #(
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [1:0]       s,
  input  logic             auto_en,
  output logic [W-1:0]     o0,
  output logic [W-1:0]     o1,
  output logic [W-1:0]     o2,
  output logic [W-1:0]     o3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic [1:0]       cur_sel,
  output logic [CNT_W-1:0] acc_cnt
);

  logic [W-1:0]     r_data [4];
  logic [3:0]       r_valid;
  logic [1:0]       r_rr;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0] w_tgt;
  logic       w_ready;
  logic       w_acc;

  assign w_tgt   = auto_en ? r_rr : s;
  // A full target lane still accepts when its consumer drains on the same edge.
  assign w_ready = !r_valid[w_tgt] | o_ready[w_tgt];
  assign w_acc   = i_valid & w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_data[k] <= '0;
      r_valid <= 4'b0000;
      r_rr    <= 2'd0;
      r_cnt   <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_acc && (w_tgt == 2'(k))) begin
          r_data[k]  <= i;
          r_valid[k] <= 1'b1;
        end else if (r_valid[k] && o_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
        if (auto_en) r_rr <= r_rr + 2'd1;
      end
    end
  end

  assign i_ready = w_ready;
  assign cur_sel = w_tgt;
  assign o0      = r_data[0];
  assign o1      = r_data[1];
  assign o2      = r_data[2];
  assign o3      = r_data[3];
  assign o_valid = r_valid;
  assign acc_cnt = r_cnt;

endmodule

// File: tb/tb_demux1_4_buf.sv
// Directed bench for demux1_4_buf: reset, manual steering, backpressure,
// lane independence, round-robin and counter wrap.
module tb_demux1_4_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i;
  logic       i_valid;
  logic       i_ready;
  logic [1:0] s;
  logic       auto_en;
  logic [1:0] o0, o1, o2, o3;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
  logic [1:0] cur_sel;
  logic [7:0] acc_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_o [4];
  logic [3:0] exp_v;

  demux1_4_buf #(.W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .s(s), .auto_en(auto_en), .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .o_valid(o_valid), .o_ready(o_ready), .cur_sel(cur_sel), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_lanes(input string tag);
    check({tag, " o0"}, 32'(o0), 32'(exp_o[0]));
    check({tag, " o1"}, 32'(o1), 32'(exp_o[1]));
    check({tag, " o2"}, 32'(o2), 32'(exp_o[2]));
    check({tag, " o3"}, 32'(o3), 32'(exp_o[3]));
    check({tag, " o_valid"}, 32'(o_valid), 32'(exp_v));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) exp_o[k] = 2'b00;
    exp_v = 4'b0000;
  endtask

  logic [1:0] vi [8];
  logic [1:0] vs [8];
  logic [1:0] rr_data [5];
  logic [1:0] rr_lane [5];
  logic [3:0] one_hot;

  initial begin
    vi = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    vs = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    rr_data = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    rr_lane = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held with a word offered
    rst_n = 1'b0; i_valid = 1'b1; i = 2'b11; s = 2'd0; auto_en = 1'b0; o_ready = 4'b0000;
    clear_model();
    repeat (3) step();
    check_lanes("reset");
    check("reset acc_cnt", 32'(acc_cnt), 32'd0);
    check("reset i_ready", 32'(i_ready), 32'd1);
    rst_n = 1'b1;

    // Manual steering, all consumers ready
    o_ready = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      i = vi[n]; s = vs[n]; i_valid = 1'b1;
      step();
      exp_o[vs[n]] = vi[n];
      one_hot = 4'b0001 << vs[n];
      exp_v = one_hot;
      check_lanes($sformatf("manual[%0d]", n));
      check($sformatf("manual[%0d] acc_cnt", n), 32'(acc_cnt), 32'(n + 1));
    end
    check("manual final acc_cnt", 32'(acc_cnt), 32'd8);

    // Async reset mid-burst, observed before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async o_valid", 32'(o_valid), 32'd0);
    check("async acc_cnt", 32'(acc_cnt), 32'd0);
    check("async o3", 32'(o3), 32'd0);
    i_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    clear_model();

    // Backpressure on lane 2
    o_ready = 4'b0000; s = 2'd2; i = 2'b01; i_valid = 1'b1;
    step();
    exp_o[2] = 2'b01; exp_v = 4'b0100;
    check_lanes("bp first");
    check("bp first i_ready", 32'(i_ready), 32'd0);
    check("bp first acc_cnt", 32'(acc_cnt), 32'd1);
    i = 2'b10;
    step();
    check_lanes("bp held");
    check("bp held acc_cnt", 32'(acc_cnt), 32'd1);
    o_ready = 4'b0100;
    #1;
    check("bp release i_ready", 32'(i_ready), 32'd1);
    step();
    exp_o[2] = 2'b10;
    check_lanes("bp replace");
    check("bp replace acc_cnt", 32'(acc_cnt), 32'd2);

    // Full lane 2 must not block lane 0
    i_valid = 1'b0; o_ready = 4'b0000;
    step();
    check_lanes("lane2 idle");
    s = 2'd0; i = 2'b11; i_valid = 1'b1;
    #1;
    check("nonblock i_ready", 32'(i_ready), 32'd1);
    step();
    exp_o[0] = 2'b11; exp_v = 4'b0101;
    check_lanes("nonblock");
    check("nonblock acc_cnt", 32'(acc_cnt), 32'd3);

    // Round-robin with wrap
    o_ready = 4'b1111; auto_en = 1'b1;
    for (int n = 0; n < 5; n++) begin
      i = rr_data[n];
      #1;
      check($sformatf("rr[%0d] cur_sel", n), 32'(cur_sel), 32'(rr_lane[n]));
      step();
      exp_o[rr_lane[n]] = rr_data[n];
      exp_v = 4'b0001 << rr_lane[n];
      check_lanes($sformatf("rr[%0d]", n));
      check($sformatf("rr[%0d] acc_cnt", n), 32'(acc_cnt), 32'(4 + n));
    end

    // Back to manual: s steers, rr holds at 1
    auto_en = 1'b0; s = 2'd2; i = 2'b10;
    #1;
    check("manual cur_sel", 32'(cur_sel), 32'd2);
    step();
    exp_o[2] = 2'b10; exp_v = 4'b0100;
    check_lanes("manual after rr");
    i_valid = 1'b0; auto_en = 1'b1;
    #1;
    check("rr held cur_sel", 32'(cur_sel), 32'd1);
    auto_en = 1'b0;

    // Counter wrap from a clean reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    s = 2'd0; i = 2'b01; i_valid = 1'b1; o_ready = 4'b1111;
    repeat (255) step();
    check("wrap 255", 32'(acc_cnt), 32'd255);
    step();
    check("wrap 256", 32'(acc_cnt), 32'd0);
    step();
    check("wrap 257", 32'(acc_cnt), 32'd1);
    i_valid = 1'b0;
    step();
    check("idle acc_cnt", 32'(acc_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
